// File: rtl/fxp_acc_pkg.sv
// Shared types and width helpers for the fixed-point frame accumulator.
// Rounding mode is selected by FXP_ACC_ROUND_EN (see fxp_round_sat).
package fxp_acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ROUND,
        HOLD
    } state_e;

    function automatic int acc_w(input int n_in, input int guard, input int m_in);
        return n_in + guard + m_in;
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational rounding and saturation of the accumulator into Q(N_OUT).(M_OUT).
// FXP_ACC_ROUND_EN defined: round-half-up; undefined: truncate (floor).
module fxp_round_sat
    import fxp_acc_pkg::*;
#(
    parameter int ACC_W = 20,
    parameter int M_IN  = 6,
    parameter int N_OUT = 5,
    parameter int M_OUT = 3
) (
    input  logic [ACC_W-1:0]       i_acc,
    input  logic                   i_ovf,
    output logic [N_OUT+M_OUT-1:0] o_data,
    output logic                   o_sat
);

    localparam int D     = M_IN - M_OUT;
    localparam int OUT_W = N_OUT + M_OUT;

`ifdef FXP_ACC_ROUND_EN
    // Half of one output LSB; shifting right after the left shift yields 0 when D=0.
    localparam logic [ACC_W:0] RND = ((ACC_W+1)'(1) << D) >> 1;
`else
    localparam logic [ACC_W:0] RND = '0;
`endif

    logic [ACC_W:0] w_sum;
    logic [ACC_W:0] w_q;
    logic           w_over;

    // Extra top bit absorbs the rounding carry so saturation sees it.
    assign w_sum  = {1'b0, i_acc} + RND;
    assign w_q    = w_sum >> D;
    assign w_over = |w_q[ACC_W:OUT_W];
    assign o_sat  = w_over | i_ovf;
    assign o_data = o_sat ? '1 : w_q[OUT_W-1:0];

endmodule

// File: rtl/fixed_point_accumulator.sv
// Frame accumulator for unsigned fixed-point products with rounded, saturated result.
// Rounding mode is selected by FXP_ACC_ROUND_EN (default: truncate).
module fixed_point_accumulator
    import fxp_acc_pkg::*;
#(
    parameter int N_IN  = 10,
    parameter int M_IN  = 6,
    parameter int N_OUT = 5,
    parameter int M_OUT = 3,
    parameter int GUARD = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN+M_IN-1:0]   in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_OUT+M_OUT-1:0] out_data,
    output logic                   out_sat,
    output logic [CNT_W-1:0]       out_count
);

    localparam int ACC_W = acc_w(N_IN, GUARD, M_IN);
    localparam int OUT_W = N_OUT + M_OUT;

    state_e             r_state;
    state_e             w_next;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_count;
    logic               r_out_valid;
    logic [OUT_W-1:0]   r_out_data;
    logic               r_out_sat;
    logic [CNT_W-1:0]   r_out_count;

    logic               w_beat;
    logic               w_first;
    logic [ACC_W-1:0]   w_base;
    logic [ACC_W:0]     w_add;
    logic [OUT_W-1:0]   w_rs_data;
    logic               w_rs_sat;

    assign in_ready = (r_state == IDLE) || (r_state == ACCUM);
    assign w_beat   = in_valid & in_ready;
    assign w_first  = (r_state == IDLE);

    // First beat of a frame starts from zero instead of the stale sum.
    assign w_base = w_first ? '0 : r_acc;
    assign w_add  = {1'b0, w_base} + (ACC_W+1)'(in_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_beat) begin
                    w_next = in_last ? ROUND : ACCUM;
                end
            end
            ACCUM: begin
                if (w_beat && in_last) begin
                    w_next = ROUND;
                end
            end
            ROUND: begin
                w_next = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
        endcase
    end

    fxp_round_sat #(
        .ACC_W (ACC_W),
        .M_IN  (M_IN),
        .N_OUT (N_OUT),
        .M_OUT (M_OUT)
    ) u_round_sat (
        .i_acc  (r_acc),
        .i_ovf  (r_ovf),
        .o_data (w_rs_data),
        .o_sat  (w_rs_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_out_count <= '0;
        end else begin
            if (w_beat) begin
                r_acc <= w_add[ACC_W] ? '1 : w_add[ACC_W-1:0];
                r_ovf <= (r_ovf & ~w_first) | w_add[ACC_W];
                if (w_first) begin
                    r_count <= CNT_W'(1);
                end else if (r_count != '1) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
            if (r_state == ROUND) begin
                r_out_data  <= w_rs_data;
                r_out_sat   <= w_rs_sat;
                r_out_count <= r_count;
                r_out_valid <= 1'b1;
            end
            if (r_state == HOLD && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign out_count = r_out_count;

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Self-checking bench for fixed_point_accumulator (Q10.6 in, Q5.3 out).
// Expected results are queued at stimulus time and popped at the output.
module tb_fixed_point_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_sat;
    logic [7:0]  out_count;

    typedef struct {
        logic [7:0] data;
        logic       sat;
        logic [7:0] count;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] fr[$];
    int          n_chk;
    int          n_err;

    fixed_point_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: 20-bit clamped sum, sticky overflow, round/floor to Q5.3.
    function automatic exp_t model();
        exp_t    e;
        longint  acc;
        longint  q;
        bit      ovf;
        acc = 0;
        ovf = 0;
        foreach (fr[i]) begin
            acc += longint'(fr[i]);
            if (acc > 64'd1048575) begin
                acc = 1048575;
                ovf = 1;
            end
        end
`ifdef FXP_ACC_ROUND_EN
        q = (acc + 4) >> 3;
`else
        q = acc >> 3;
`endif
        e.sat   = ovf || (q > 255);
        e.data  = e.sat ? 8'hFF : 8'(q);
        e.count = (fr.size() > 255) ? 8'hFF : 8'(fr.size());
        return e;
    endfunction

    task automatic put_beat(input logic [15:0] d, input logic last);
        int wait_n;
        @(negedge clk);
        wait_n = 0;
        while (!in_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
    endtask

    task automatic drive_frame();
        sb.push_back(model());
        foreach (fr[i]) put_beat(fr[i], (i == fr.size() - 1));
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("lat_round_low", 32'(out_valid), 0);
        check("ready_in_round", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        check("lat_valid_high", 32'(out_valid), 1);
    endtask

    task automatic collect(input int hold);
        exp_t       e;
        logic [7:0] snap;
        snap = out_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 1);
            check("hold_data", 32'(out_data), 32'(snap));
            check("hold_in_ready", 32'(in_ready), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        if (sb.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_sat", 32'(out_sat), 32'(e.sat));
            check("out_count", 32'(out_count), 32'(e.count));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("drop_valid", 32'(out_valid), 0);
        check("idle_in_ready", 32'(in_ready), 1);
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_sat", 32'(out_sat), 0);
        check("rst_count", 32'(out_count), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);

        fr = '{16'h07E0};
        drive_frame();
        collect(1);

        fr = '{16'h0048, 16'h0048};
        drive_frame();
        collect(1);

        fr = '{16'h07E0, 16'h07E0};
        drive_frame();
        collect(1);

        fr = '{16'h0004};
        drive_frame();
        collect(1);

        fr = '{16'h0030, 16'h0100};
        drive_frame();
        collect(5);

        fr = '{};
        for (int i = 0; i < 17; i++) fr.push_back(16'hFFFF);
        drive_frame();
        collect(1);

        fr = '{};
        for (int i = 0; i < 260; i++) fr.push_back(16'h0000);
        fr[100] = 16'h000C;
        drive_frame();
        collect(1);

        for (int k = 0; k < 4; k++) begin
            fr = '{};
            for (int i = 0; i < int'($urandom_range(1, 4)); i++)
                fr.push_back(16'($urandom_range(0, 16'h0400)));
            drive_frame();
            collect(int'($urandom_range(0, 2)));
        end

        put_beat(16'h0100, 1'b0);
        put_beat(16'h0100, 1'b0);
        put_beat(16'h0100, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("mid_rst_count", 32'(out_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("mid_rst_no_valid", 32'(out_valid), 0);
        end

        fr = '{16'h0048};
        drive_frame();
        collect(1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
